// File: rtl/bju_resolve.sv
// Execute-stage branch resolution: computes the real outcome of jal/jalr/bxx, flushes and
// redirects fetch on a mispredict, writes back pc+4 links. Optional counters: BJU_PERF_EN.
module bju_resolve #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_vld,
    output logic            o_rdy,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_inst_jal,
    input  logic            i_inst_jalr,
    input  logic            i_inst_bxx,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_rdata,
    input  logic [XLEN-1:0] i_rs2_rdata,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_prdt_taken,
    input  logic [XLEN-1:0] i_prdt_pc,
    output logic            o_wb_vld,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_flush,
    output logic            o_redirect_vld,
    output logic [XLEN-1:0] o_redirect_pc,
    input  logic            i_redirect_rdy,
    output logic [31:0]     o_perf_br_cnt,
    output logic [31:0]     o_perf_mis_cnt
);

    typedef enum logic {IDLE, REDIR} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_vld_q, wb_vld_d;
    logic            flush_q, flush_d;

    logic            accept, is_cti, is_link;
    logic            eq, ult, slt, cond, taken, mispredict;
    logic [XLEN-1:0] pc_plus4, br_target, jalr_sum, target, next_pc;

    assign o_rdy   = (state_q == IDLE);
    assign accept  = i_vld & o_rdy;
    assign is_link = i_inst_jal | i_inst_jalr;
    assign is_cti  = is_link | i_inst_bxx;

    // Signed less-than reuses the unsigned compare unless the sign bits differ.
    assign eq  = (i_rs1_rdata == i_rs2_rdata);
    assign ult = (i_rs1_rdata < i_rs2_rdata);
    assign slt = (i_rs1_rdata[XLEN-1] ^ i_rs2_rdata[XLEN-1]) ? i_rs1_rdata[XLEN-1] : ult;

    always_comb begin
        cond = 1'b0;
        case (i_funct3)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = slt;
            3'b101:  cond = ~slt;
            3'b110:  cond = ult;
            3'b111:  cond = ~ult;
            default: cond = 1'b0;
        endcase
    end

    assign pc_plus4   = i_pc + XLEN'(4);
    assign br_target  = i_pc + i_imm;
    assign jalr_sum   = i_rs1_rdata + i_imm;
    assign target     = i_inst_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;
    assign taken      = is_link | (i_inst_bxx & cond);
    assign next_pc    = taken ? target : pc_plus4;
    assign mispredict = (taken != i_prdt_taken) | (taken & (target != i_prdt_pc));

    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        wb_vld_d   = 1'b0;
        wb_data_d  = '0;
        flush_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && is_link) begin
                    wb_vld_d  = 1'b1;
                    wb_data_d = pc_plus4;
                end
                if (accept && is_cti && mispredict) begin
                    flush_d    = 1'b1;
                    redir_pc_d = next_pc;
                    state_d    = REDIR;
                end
            end
            REDIR: begin
                if (i_redirect_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            redir_pc_q <= '0;
            wb_vld_q   <= 1'b0;
            wb_data_q  <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            wb_vld_q   <= wb_vld_d;
            wb_data_q  <= wb_data_d;
            flush_q    <= flush_d;
        end
    end

    assign o_wb_vld       = wb_vld_q;
    assign o_wb_data      = wb_data_q;
    assign o_flush        = flush_q;
    assign o_redirect_vld = (state_q == REDIR);
    assign o_redirect_pc  = redir_pc_q;

`ifdef BJU_PERF_EN
    logic [31:0] br_cnt_q, mis_cnt_q;

    // Counted at the accept edge so they line up with the registered result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (accept && is_cti) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredict) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign o_perf_br_cnt  = br_cnt_q;
    assign o_perf_mis_cnt = mis_cnt_q;
`else
    assign o_perf_br_cnt  = 32'd0;
    assign o_perf_mis_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bju_resolve.sv
// Scoreboard bench for bju_resolve: directed cases then randomized traffic against a
// behavioural model; a negedge monitor pops expected writebacks and redirects.
module tb_bju_resolve;

    typedef struct {
        logic        vld, jal, jalr, bxx, pt;
        logic [2:0]  f3;
        logic [31:0] pc, rs1, rs2, imm, ppc;
    } instr_t;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

`ifdef BJU_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        i_clk = 1'b0, i_rst = 1'b1, i_vld = 1'b0;
    logic        i_inst_jal = 1'b0, i_inst_jalr = 1'b0, i_inst_bxx = 1'b0;
    logic        i_prdt_taken = 1'b0, i_redirect_rdy = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_pc = '0, i_rs1_rdata = '0, i_rs2_rdata = '0, i_imm = '0, i_prdt_pc = '0;
    logic        o_rdy, o_wb_vld, o_flush, o_redirect_vld;
    logic [31:0] o_wb_data, o_redirect_pc, o_perf_br_cnt, o_perf_mis_cnt;

    int   checks = 0, errors = 0, cyc = 0;
    bit   monOn = 1'b0;
    bit   modelIdle = 1'b1;
    logic [31:0] modelRedirPc = '0, modelBr = '0, modelMis = '0;
    exp_t wbQ[$], rdQ[$];

    bju_resolve #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_pc(i_pc),
        .i_inst_jal(i_inst_jal), .i_inst_jalr(i_inst_jalr), .i_inst_bxx(i_inst_bxx),
        .i_funct3(i_funct3), .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
        .i_imm(i_imm), .i_prdt_taken(i_prdt_taken), .i_prdt_pc(i_prdt_pc),
        .o_wb_vld(o_wb_vld), .o_wb_data(o_wb_data), .o_flush(o_flush),
        .o_redirect_vld(o_redirect_vld), .o_redirect_pc(o_redirect_pc),
        .i_redirect_rdy(i_redirect_rdy), .o_perf_br_cnt(o_perf_br_cnt),
        .o_perf_mis_cnt(o_perf_mis_cnt)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference outcome straight from the ISA rules, using plain integer arithmetic.
    function automatic bit refTaken(input instr_t in);
        longint a = longint'($signed(in.rs1));
        longint b = longint'($signed(in.rs2));
        longint ua = longint'({32'b0, in.rs1});
        longint ub = longint'({32'b0, in.rs2});
        if (in.jal || in.jalr) return 1'b1;
        if (!in.bxx) return 1'b0;
        case (in.f3)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return a < b;
            3'd5: return a >= b;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] refTarget(input instr_t in);
        longint s;
        if (in.jalr) begin
            s = (longint'({32'b0, in.rs1}) + longint'({32'b0, in.imm})) % 64'h1_0000_0000;
            return 32'(s - (s % 2));
        end
        s = (longint'({32'b0, in.pc}) + longint'({32'b0, in.imm})) % 64'h1_0000_0000;
        return 32'(s);
    endfunction

    function automatic instr_t mk(input int kind, input logic [2:0] f3, input logic [31:0] pc,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic pt, input logic [31:0] ppc);
        instr_t r;
        r.vld = (kind >= 0);
        r.jal = (kind == 1); r.jalr = (kind == 2); r.bxx = (kind == 3);
        r.f3 = f3; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.pt = pt; r.ppc = ppc;
        return r;
    endfunction

    task automatic checkOutput();
        checkEq("rdy", 32'(o_rdy), 32'(modelIdle));
        checkEq("redirVld", 32'(o_redirect_vld), 32'(!modelIdle));
        if (!modelIdle) checkEq("redirPcHeld", o_redirect_pc, modelRedirPc);
        checkEq("perfBr", o_perf_br_cnt, PerfEn ? modelBr : 32'd0);
        checkEq("perfMis", o_perf_mis_cnt, PerfEn ? modelMis : 32'd0);
    endtask

    // One cycle: check the current cycle, drive new inputs, advance the model to the next edge.
    task automatic applyStimulus(input instr_t in, input logic rrdy, input logic rst);
        bit   tk, mis;
        logic [31:0] tgt, nxt;
        @(posedge i_clk); #1;
        checkOutput();
        i_rst = rst; i_vld = in.vld; i_inst_jal = in.jal; i_inst_jalr = in.jalr;
        i_inst_bxx = in.bxx; i_funct3 = in.f3; i_pc = in.pc; i_rs1_rdata = in.rs1;
        i_rs2_rdata = in.rs2; i_imm = in.imm; i_prdt_taken = in.pt; i_prdt_pc = in.ppc;
        i_redirect_rdy = rrdy;
        if (rst) begin
            modelIdle = 1'b1; modelBr = '0; modelMis = '0;
        end else if (modelIdle && in.vld && (in.jal || in.jalr || in.bxx)) begin
            tk  = refTaken(in);
            tgt = refTarget(in);
            nxt = tk ? tgt : in.pc + 32'd4;
            mis = (tk != in.pt) || (tk && tgt != in.ppc);
            modelBr++;
            if (in.jal || in.jalr) wbQ.push_back('{cyc + 1, in.pc + 32'd4});
            if (mis) begin
                rdQ.push_back('{cyc + 1, nxt});
                modelMis++;
                modelIdle = 1'b0;
                modelRedirPc = nxt;
            end
        end else if (!modelIdle && rrdy) begin
            modelIdle = 1'b1;
        end
    endtask

    always @(negedge i_clk) begin
        if (monOn) begin
            if (o_wb_vld === 1'b1) begin
                if (wbQ.size() > 0 && wbQ[0].due == cyc) begin
                    checkEq("wbData", o_wb_data, wbQ[0].val);
                    void'(wbQ.pop_front());
                end else checkEq("wbVldUnexpected", 32'(o_wb_vld), 32'd0);
            end else if (wbQ.size() > 0 && wbQ[0].due == cyc) begin
                checkEq("wbVldMissing", 32'(o_wb_vld), 32'd1);
                void'(wbQ.pop_front());
            end
            if (o_flush === 1'b1) begin
                if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
                    checkEq("redirPc", o_redirect_pc, rdQ[0].val);
                    checkEq("redirVldWithFlush", 32'(o_redirect_vld), 32'd1);
                    void'(rdQ.pop_front());
                end else checkEq("flushUnexpected", 32'(o_flush), 32'd0);
            end else if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
                checkEq("flushMissing", 32'(o_flush), 32'd1);
                void'(rdQ.pop_front());
            end
        end
    end

    instr_t nop, rnd;
    int kind;

    initial begin
        nop = mk(-1, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        monOn = 1'b1;
        checkEq("resetRedirPc", o_redirect_pc, 32'd0);
        checkEq("resetWbVld", 32'(o_wb_vld), 32'd0);
        checkEq("resetFlush", 32'(o_flush), 32'd0);

        applyStimulus(mk(3, 3'd0, 32'h100, 32'd5, 32'd5, 32'hFFFF_FFF0, 1'b1, 32'hF0), 1'b0, 1'b0);
        applyStimulus(mk(3, 3'd1, 32'h200, 32'd7, 32'd7, 32'h20, 1'b1, 32'h220), 1'b0, 1'b0);
        repeat (3) applyStimulus(mk(1, 3'd0, 32'h800, 32'd0, 32'd0, 32'h8, 1'b0, 32'd0), 1'b0, 1'b0);
        applyStimulus(nop, 1'b1, 1'b0);
        applyStimulus(mk(2, 3'd0, 32'h300, 32'h1001, 32'd0, 32'd4, 1'b0, 32'd0), 1'b1, 1'b0);
        applyStimulus(nop, 1'b1, 1'b0);
        applyStimulus(mk(3, 3'd6, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'd0), 1'b0, 1'b0);
        applyStimulus(mk(3, 3'd4, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'd0), 1'b0, 1'b0);
        applyStimulus(nop, 1'b1, 1'b0);
        applyStimulus(mk(1, 3'd0, 32'h500, 32'd0, 32'd0, 32'h10, 1'b1, 32'h510), 1'b0, 1'b0);
        applyStimulus(mk(1, 3'd0, 32'h510, 32'd0, 32'd0, 32'h20, 1'b1, 32'h530), 1'b0, 1'b0);
        applyStimulus(mk(1, 3'd0, 32'h600, 32'd0, 32'd0, 32'h40, 1'b0, 32'd0), 1'b0, 1'b0);
        applyStimulus(nop, 1'b0, 1'b1);
        applyStimulus(nop, 1'b0, 1'b0);
        applyStimulus(mk(1, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b1, 32'd4), 1'b0, 1'b0);
        applyStimulus(nop, 1'b0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            kind = $urandom_range(0, 3);
            rnd = mk(kind, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC, $urandom,
                     $urandom, 32'($urandom_range(0, 4095)) - 32'd2048, 1'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) rnd.rs2 = rnd.rs1;
            if ($urandom_range(0, 3) == 0) rnd.rs1[31] = ~rnd.rs2[31];
            if ($urandom_range(0, 1) == 0) rnd.ppc = refTarget(rnd);
            rnd.vld = ($urandom_range(0, 9) < 7);
            applyStimulus(rnd, 1'($urandom), ($urandom_range(0, 63) == 0));
        end

        repeat (4) applyStimulus(nop, 1'b1, 1'b0);
        @(negedge i_clk);
        #1;
        checkEq("wbQueueDrained", 32'(wbQ.size()), 32'd0);
        checkEq("redirQueueDrained", 32'(rdQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bju_resolve.md
Name: bju_resolve

Overview:
Execute-stage branch resolution unit, the back end of the fetch-stage static predictor.
- Takes each control-transfer instruction with the prediction made at fetch (taken flag, predicted pc) and computes the real outcome: branch compare, jalr rs1+imm.
- On a misprediction it pulses a pipeline flush and holds a redirect request to fetch until accepted.
- Writes back the link value (pc+4) for jal/jalr.

Parameters:
XLEN, 32, data/address width.

Ports:
i_clk  input  1  clock, all logic on rising edge.
i_rst  input  1  synchronous reset, active-high.
i_vld  input  1  instruction valid from issue.
o_rdy  output  1  unit can accept; handshake on i_vld&o_rdy.
i_pc  input  XLEN  pc of instruction.
i_inst_jal  input  1  jal.
i_inst_jalr  input  1  jalr.
i_inst_bxx  input  1  conditional branch.
i_funct3  input  3  branch condition (RV32I encoding).
i_rs1_rdata  input  XLEN  rs1 value.
i_rs2_rdata  input  XLEN  rs2 value.
i_imm  input  XLEN  sign-extended immediate.
i_prdt_taken  input  1  fetch prediction: taken.
i_prdt_pc  input  XLEN  fetch predicted target.
o_wb_vld  output  1  link writeback valid (jal/jalr).
o_wb_data  output  XLEN  link value pc+4.
o_flush  output  1  one-cycle squash of younger instructions.
o_redirect_vld  output  1  redirect request to fetch.
o_redirect_pc  output  XLEN  correct next pc.
i_redirect_rdy  input  1  fetch accepts redirect.
o_perf_br_cnt  output  32  resolved control-transfer count.
o_perf_mis_cnt  output  32  misprediction count.

Behaviour:
- Reset, synchronous, i_rst high: all outputs 0, FSM to IDLE, any pending redirect dropped, perf counters 0.
- FSM states:
  - IDLE: o_rdy=1.
  - REDIR: redirect pending, o_rdy=0.
- Accept at edge N when i_vld&o_rdy. Results are registered at edge N and visible in cycle N+1 (latency 1).
- Instruction with none of jal/jalr/bxx: accepted, produces no outputs, not counted.
- Actual taken:
  - jal, jalr: always taken.
  - bxx by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - bxx with funct3 010/011: not taken.
- Target, modulo 2^XLEN:
  - jal, bxx: pc+imm.
  - jalr: (rs1+imm) with bit0 cleared.
- Correct next pc = taken ? target : pc+4, with wrap at 2^XLEN.
- Mispredict = (taken != i_prdt_taken) | (taken & target != i_prdt_pc).
- A not-taken instruction with i_prdt_taken=0 is never a mispredict, regardless of i_prdt_pc.
- Cycle N+1:
  - o_wb_vld=1 for exactly one cycle if jal/jalr, with o_wb_data=pc+4.
  - On mispredict: o_flush=1 for exactly one cycle, o_redirect_vld=1, o_redirect_pc=next pc, FSM to REDIR.
  - On correct prediction: FSM stays IDLE and a back-to-back accept is allowed in cycle N+1.
- REDIR:
  - o_redirect_vld and o_redirect_pc held stable until i_redirect_rdy is sampled high.
  - On that edge FSM goes to IDLE; o_redirect_vld=0 and o_rdy=1 from the following cycle.
  - i_vld is ignored while o_rdy=0.
  - o_flush is never re-pulsed while waiting.
- i_redirect_rdy high in the very first REDIR cycle (N+1): handshake completes at edge N+1; IDLE in N+2.
- i_rst asserted during REDIR: request withdrawn the next cycle, no flush emitted.

Optional Feature:
BJU_PERF_EN
- Defined:
  - o_perf_br_cnt increments on each accepted jal/jalr/bxx.
  - o_perf_mis_cnt increments on each mispredict, at the same edge the result registers.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- bxx beq, pc=0x100, rs1=rs2=5, imm=0xFFFFFFF0, prdt_taken=1, prdt_pc=0xF0 -> no flush, no redirect, o_rdy stays 1, mis_cnt 0.
- bxx bne, pc=0x200, rs1=rs2=7, imm=0x20, prdt_taken=1, prdt_pc=0x220 -> flush one cycle, redirect_pc=0x204; with i_redirect_rdy low 3 cycles, o_redirect_vld held 4 cycles and o_rdy=0 throughout.
- jalr, pc=0x300, rs1=0x1001, imm=4, prdt_taken=0 -> wb_vld with data 0x304, flush, redirect_pc=0x1004 (bit0 cleared).
- bltu vs blt, rs1=0xFFFFFFFF, rs2=1, imm=0x40, pc=0x400, prdt_taken=0:
  - bltu: no redirect.
  - blt: taken, redirect_pc=0x440.
- Back-to-back: two correctly predicted jal in consecutive cycles -> two wb_vld pulses; then i_rst during REDIR -> o_redirect_vld=0 next cycle, counters 0 (with BJU_PERF_EN).
- Wrap: jal, pc=0xFFFFFFFC, imm=8, prdt_taken=1, prdt_pc=4 -> no redirect, o_wb_data=0x00000000.
